// File: rtl/bram_in_arbiter_pkg.sv
// Shared constants and helpers for the BRAM input write arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bram_in_arbiter_pkg;

    localparam int N_SRC  = 20;  // requesting lanes / mux data inputs
    localparam int SEL_W  = 5;   // mux select width, 2**SEL_W >= N_SRC
    localparam int ADDR_W = 10;  // BRAM write address width
    localparam int CNT_W  = 16;  // write-count status width

    // Index of the set bit in a one-hot (or all-zero) lane vector.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_SRC-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_first_pick.sv
// Rotated priority encoder: first eligible lane at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_first_pick
    import bram_in_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] elig,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_SRC);

    logic [N_SRC-1:0] hit;
    logic [SEL_W:0]   cand;

    // Walk lanes ptr, ptr+1, ... modulo N_SRC and mark only the first eligible one.
    always_comb begin
        hit  = '0;
        cand = '0;
        for (int j = 0; j < N_SRC; j++) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(j);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if ((hit == '0) && elig[cand[SEL_W-1:0]]) begin
                hit[cand[SEL_W-1:0]] = 1'b1;
            end
        end
    end

    assign found = |hit;
    assign idx   = onehot_to_idx(hit);

endmodule

// File: rtl/bram_in_arbiter.sv
// Round-robin write arbiter driving BRAM mux select, write enable and address.
// Latency: one cycle from request sampled to registered grant/write.
// Backpressure: hold=1 blocks new decisions; an already registered grant still completes.
module bram_in_arbiter
    import bram_in_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC*ADDR_W-1:0] addr_in,
    input  logic                    hold,
    output logic [N_SRC-1:0]        gnt,
    output logic [SEL_W-1:0]        sel,
    output logic                    bram_we,
    output logic [ADDR_W-1:0]       bram_addr,
    output logic [CNT_W-1:0]        wr_count
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] ptr_nxt;
    logic             found;
    logic             decide;
    logic [N_SRC-1:0] elig;

    // The lane being written this cycle still has req high; keep it out of
    // the next decision so it cannot be granted twice for one write.
    assign elig   = req & ~gnt;
    assign decide = found & ~hold;
    assign ptr_nxt = (pick == SEL_W'(N_SRC - 1)) ? '0 : pick + SEL_W'(1);

    rr_first_pick u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // Grant, select, address and priority pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            sel       <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            ptr       <= '0;
        end else if (decide) begin
            gnt       <= {{(N_SRC-1){1'b0}}, 1'b1} << pick;
            sel       <= pick;
            bram_we   <= 1'b1;
            bram_addr <= addr_in[pick*ADDR_W +: ADDR_W];
            ptr       <= ptr_nxt;
        end else begin
            // sel and bram_addr keep their last values so the mux stays quiet.
            gnt     <= '0;
            bram_we <= 1'b0;
        end
    end

    // Saturating count of writes presented to the BRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (bram_we && (wr_count != '1)) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bram_in_arbiter.sv
// Self-checking bench for bram_in_arbiter: table-driven vectors plus
// hand-written sequences, expectations queued at drive time and popped at sample time.
module tb_bram_in_arbiter;
    import bram_in_arbiter_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic [N_SRC-1:0]        req;
    logic [N_SRC*ADDR_W-1:0] addr_in;
    logic                    hold;
    logic [N_SRC-1:0]        gnt;
    logic [SEL_W-1:0]        sel;
    logic                    bram_we;
    logic [ADDR_W-1:0]       bram_addr;
    logic [CNT_W-1:0]        wr_count;

    bram_in_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .addr_in   (addr_in),
        .hold      (hold),
        .gnt       (gnt),
        .sel       (sel),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_SRC-1:0]  gnt;
        logic [SEL_W-1:0]  sel;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    typedef struct {
        logic [N_SRC-1:0] req;
        logic             hold;
        exp_t             e;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    function automatic vec_t mk(input logic [N_SRC-1:0] r, input logic h,
                                input logic [N_SRC-1:0] g, input int s, input logic w,
                                input int a, input int c);
        vec_t v;
        v.req    = r;
        v.hold   = h;
        v.e.gnt  = g;
        v.e.sel  = SEL_W'(s);
        v.e.we   = w;
        v.e.addr = ADDR_W'(a);
        v.e.cnt  = CNT_W'(c);
        return v;
    endfunction

    // Stimulus address map: lane i writes address i, except lane 7 uses 0x15.
    function automatic logic [ADDR_W-1:0] lane_addr(input int i);
        return (i == 7) ? ADDR_W'(10'h015) : ADDR_W'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        vectors++;
        if (act !== req_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req_v);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".gnt"},       32'(gnt),       32'(e.gnt));
        chk({tag, ".sel"},       32'(sel),       32'(e.sel));
        chk({tag, ".bram_we"},   32'(bram_we),   32'(e.we));
        chk({tag, ".bram_addr"}, 32'(bram_addr), 32'(e.addr));
        chk({tag, ".wr_count"},  32'(wr_count),  32'(e.cnt));
    endtask

    // One clock: outputs registered on this edge are compared 2 ns later.
    task automatic step_check(input string tag);
        exp_t e;
        @(posedge clk);
        #2;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk_all(tag, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        exp_t e;
        vectors     = 0;
        miscompares = 0;
        z.gnt = '0; z.sel = '0; z.we = 1'b0; z.addr = '0; z.cnt = '0;

        // Reset with random activity on the inputs.
        rst_n = 1'b0;
        req   = N_SRC'($urandom);
        hold  = 1'($urandom);
        for (int i = 0; i < N_SRC; i++) addr_in[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        repeat (3) @(posedge clk);
        #2;
        chk_all("reset", z);

        for (int i = 0; i < N_SRC; i++) addr_in[i*ADDR_W +: ADDR_W] = lane_addr(i);
        req   = '0;
        hold  = 1'b0;
        rst_n = 1'b1;

        // Stall (ptr=0 after reset), hold rising over a presented grant,
        // single request on lane 7, then a lone stream on lane 3.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(20'h00204, 1'b1, 20'h0, 0, 1'b0, 0, 0));
        tbl.push_back(mk(20'h00204, 1'b0, 20'h00004, 2, 1'b1, 2,    0));
        tbl.push_back(mk(20'h00204, 1'b0, 20'h00200, 9, 1'b1, 9,    1));
        tbl.push_back(mk(20'h00000, 1'b1, 20'h00000, 9, 1'b0, 9,    2));
        tbl.push_back(mk(20'h00000, 1'b0, 20'h00000, 9, 1'b0, 9,    2));
        tbl.push_back(mk(20'h00080, 1'b0, 20'h00080, 7, 1'b1, 'h15, 2));
        tbl.push_back(mk(20'h00000, 1'b0, 20'h00000, 7, 1'b0, 'h15, 3));
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) tbl.push_back(mk(20'h00008, 1'b0, 20'h00008, 3, 1'b1, 3, 3 + i/2));
            else            tbl.push_back(mk(20'h00008, 1'b0, 20'h00000, 3, 1'b0, 3, 4 + i/2));
        end
        tbl.push_back(mk(20'h00000, 1'b0, 20'h00000, 3, 1'b0, 3, 8));

        foreach (tbl[n]) begin
            req  = tbl[n].req;
            hold = tbl[n].hold;
            exp_q.push_back(tbl[n].e);
            step_check($sformatf("tbl%0d", n));
        end

        // Clear pointer and counter with a mid-cycle reset pulse.
        req   = '0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;

        // Full contention: sel walks 0..19, wraps to 0, continues to 12.
        req = '1;
        for (int c = 0; c <= 32; c++) begin
            e.gnt  = N_SRC'(1) << (c % N_SRC);
            e.sel  = SEL_W'(c % N_SRC);
            e.we   = 1'b1;
            e.addr = lane_addr(c % N_SRC);
            e.cnt  = CNT_W'(c);
            exp_q.push_back(e);
            step_check($sformatf("full%0d", c));
        end

        // Asynchronous reset between edges while sel=12.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", z);
        #1;
        rst_n = 1'b1;

        // First grants after release restart at lane 0.
        for (int c = 0; c < 2; c++) begin
            e.gnt  = N_SRC'(1) << c;
            e.sel  = SEL_W'(c);
            e.we   = 1'b1;
            e.addr = lane_addr(c);
            e.cnt  = CNT_W'(c);
            exp_q.push_back(e);
            step_check($sformatf("post_rst%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
